wifi_scrambler_par: RTL and testbench
=====================================

// Module: wifi_scrambler_par
// PURPOSE
// Parametrised 802.11 scrambler/descrambler, polynomial x^7+x^4+1, processing DW bits per clock.
// Sits between the PPDU bit source and the encoder (TX, mode=0), or between the decoder and the MAC sink (RX, mode=1).
// TX: loads a per-frame seed. RX: self-synchronises by recovering the LFSR state from the first 7 SERVICE bits.
// Has a valid/ready stream interface with SOP/EOP framing and one register stage.
// PARAMETERS
// DW            8          bits per beat, 1..16; in_data[0] is earliest in time (LSB-first)
// SEED_DEFAULT  7'h5D      seed substituted when seed_in==0 in scramble mode
// PORTS
// clk        in   1    clock, rising edge
// rst        in   1    reset, asynchronous, active-high
// mode       in   1    0=scramble with seed_in, 1=descramble with seed recovery; sampled on SOP beat
// seed_in    in   7    TX seed {x7..x1}; sampled on SOP beat
// in_valid   in   1    input beat valid
// in_ready   out  1    block can accept a beat
// in_data    in   DW   input bits
// in_sop     in   1    first beat of frame
// in_eop     in   1    last beat of frame
// out_valid  out  1    output beat valid
// out_ready  in   1    sink accepts output
// out_data   out  DW   scrambled/descrambled bits
// out_sop    out  1    SOP, aligned with out_data
// out_eop    out  1    EOP, aligned with out_data
// state_out  out  7    current LFSR state
// busy       out  1    FSM != IDLE
// err        out  1    1-cycle pulse: zero seed substituted, or non-SOP beat dropped in IDLE
// BEHAVIOUR
// - Reset values: all outputs 0, except in_ready=1. LFSR=SEED_DEFAULT, FSM=IDLE, rec_cnt=0.
// - LFSR step per bit: fb=s[6]^s[3]; out=in^fb.
//   - Scramble / RUN: s<={s[5:0],fb}.
//   - RECOVER: s<={s[5:0],in}, out bit forced 0.
// - Bits are processed in order 0..DW-1 within a beat; the state may switch RECOVER->RUN mid-beat.
// - Handshake: in_ready = !out_valid || out_ready. A beat is accepted on in_valid&&in_ready.
// - An accepted beat appears on out_* on the next clock (latency 1). out_* hold stable while out_valid&&!out_ready.
// - Full throughput: one beat per clock when out_ready=1. No combinational path from in_valid to out_valid.
// - FSM IDLE/RECOVER/RUN; transitions occur only on accepted beats:
//   - Any state + SOP, mode=0: LFSR<=seed_in (SEED_DEFAULT+err if 0) before processing the beat -> RUN.
//   - Any state + SOP, mode=1: rec_cnt<=0, beat processed in RECOVER.
//     - Go to RUN once rec_cnt reaches 7 (after ceil(7/DW) beats); else stay in RECOVER.
//   - SOP mid-frame aborts the current frame and restarts; no error is raised.
//   - IDLE + non-SOP beat: accepted and dropped (no output), err pulses.
//   - EOP beat (any state, incl. SOP+EOP): processed, then FSM -> IDLE. LFSR value is kept.
//   - Frame ending in RECOVER: remaining bits output 0, FSM -> IDLE.
// - The mode latched at SOP holds for the whole frame; mode changes mid-frame are ignored.
// - rec_cnt is 3 bits and saturates at 7.
// - rst asserted mid-frame: immediate return to reset values; the in-flight output beat is discarded.
// TESTING
// - DW=8, mode=0, seed 7'h7F, zero data SOP,+1 -> out_data 8'h70, then 8'h4F (seq 00001110 11110010).
// - DW=8, mode=0, seed 0 -> err pulse 1 cycle; output equals the seed-7'h5D stream.
// - Round trip: TX seed 7'h5D, 64 random bytes with first 7 bits 0 -> RX mode=1 output == TX input.
//   - Also: RX output bits 0..6 == 0 and busy=1 throughout.
// - DW=1, mode=1: RECOVER lasts 7 beats, outputs 0; beat 8 onward descrambled; state_out matches TX LFSR.
// - Backpressure: out_ready low 3 cycles mid-frame -> in_ready=0, out_data stable, no beat lost or duplicated.
// - rst mid-frame -> out_valid=0, state_out=7'h5D; new SOP frame afterwards is correct.
//   - Also: non-SOP beat in IDLE -> err, no output.

Source files
------------

// File: rtl/wifi_scrambler_par.sv
// 802.11 x^7+x^4+1 scrambler (mode 0) / self-synchronising descrambler (mode 1), DW bits per beat.
// Latency 1 beat; in_ready = !out_valid || out_ready, output held while stalled.
module wifi_scrambler_par #(
  parameter int         DW           = 8,
  parameter logic [6:0] SEED_DEFAULT = 7'h5D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [6:0]    seed_in,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sop,
  input  logic          in_eop,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sop,
  output logic          out_eop,
  output logic [6:0]    state_out,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, RECOVER, RUN} state_e;

  state_e        fsm_q, fsm_d;
  logic [6:0]    lfsr_q, lfsr_d;
  logic [2:0]    rec_cnt_q, rec_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;
  logic          err_q, err_d;

  logic          accept;
  logic          drop;
  state_e        st;
  logic [6:0]    s;
  logic [2:0]    cnt;
  logic          fb;
  logic [DW-1:0] dat;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    fsm_d       = fsm_q;
    lfsr_d      = lfsr_q;
    rec_cnt_d   = rec_cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    err_d       = 1'b0;
    drop        = 1'b0;
    st          = fsm_q;
    s           = lfsr_q;
    cnt         = rec_cnt_q;
    fb          = 1'b0;
    dat         = '0;

    if (accept) begin
      if (in_sop) begin
        if (!mode) begin
          st = RUN;
          if (seed_in == 7'd0) begin
            s     = SEED_DEFAULT;
            err_d = 1'b1;
          end else begin
            s = seed_in;
          end
        end else begin
          st  = RECOVER;
          cnt = 3'd0;
        end
      end else if (fsm_q == IDLE) begin
        drop  = 1'b1;
        err_d = 1'b1;
      end

      // Recovery shifts received bits straight into the LFSR; may hand over to RUN mid-beat.
      for (int i = 0; i < DW; i++) begin
        fb = s[6] ^ s[3];
        if (st == RECOVER) begin
          dat[i] = 1'b0;
          s      = {s[5:0], in_data[i]};
          if (cnt != 3'd7) cnt = cnt + 3'd1;
          if (cnt == 3'd7) st = RUN;
        end else begin
          dat[i] = in_data[i] ^ fb;
          s      = {s[5:0], fb};
        end
      end

      if (!drop) begin
        fsm_d       = in_eop ? IDLE : st;
        lfsr_d      = s;
        rec_cnt_d   = cnt;
        out_valid_d = 1'b1;
        out_data_d  = dat;
        out_sop_d   = in_sop;
        out_eop_d   = in_eop;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      lfsr_q      <= SEED_DEFAULT;
      rec_cnt_q   <= 3'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      lfsr_q      <= lfsr_d;
      rec_cnt_q   <= rec_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign state_out = lfsr_q;
  assign busy      = (fsm_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_wifi_scrambler_par.sv
// Directed bench: a DW=8 instance (TX, RX round trip, backpressure, reset) and a DW=1 RX instance.
module tb_wifi_scrambler_par;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_mode, a_in_valid, a_in_ready, a_in_sop, a_in_eop;
  logic       a_out_valid, a_out_ready, a_out_sop, a_out_eop, a_busy, a_err;
  logic [6:0] a_seed, a_state;
  logic [7:0] a_in_data, a_out_data;

  logic       b_mode, b_in_valid, b_in_ready, b_in_sop, b_in_eop;
  logic       b_out_valid, b_out_ready, b_out_sop, b_out_eop, b_busy, b_err;
  logic [6:0] b_seed, b_state;
  logic [0:0] b_in_data, b_out_data;

  wifi_scrambler_par #(.DW(8), .SEED_DEFAULT(7'h5D)) u_a (
    .clk(clk), .rst(rst), .mode(a_mode), .seed_in(a_seed),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_sop(a_in_sop), .in_eop(a_in_eop),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_sop(a_out_sop), .out_eop(a_out_eop),
    .state_out(a_state), .busy(a_busy), .err(a_err)
  );

  wifi_scrambler_par #(.DW(1), .SEED_DEFAULT(7'h5D)) u_b (
    .clk(clk), .rst(rst), .mode(b_mode), .seed_in(b_seed),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_sop(b_in_sop), .in_eop(b_in_eop),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_sop(b_out_sop), .out_eop(b_out_eop),
    .state_out(b_state), .busy(b_busy), .err(b_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output collectors: a beat is consumed when valid&&ready at the negedge before the posedge.
  logic [9:0] a_q[$];
  logic [2:0] b_q[$];
  int a_err_cnt = 0;
  int b_err_cnt = 0;
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) a_q.push_back({a_out_sop, a_out_eop, a_out_data});
    if (!rst && b_out_valid && b_out_ready) b_q.push_back({b_out_sop, b_out_eop, b_out_data});
    if (a_err) a_err_cnt++;
    if (b_err) b_err_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [7:0] d, input logic sop, input logic eop,
                        input logic md, input logic [6:0] sd);
    int n;
    n = 0;
    a_in_data = d; a_in_sop = sop; a_in_eop = eop; a_mode = md; a_seed = sd;
    a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("a_in_ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0; a_in_sop = 1'b0; a_in_eop = 1'b0;
  endtask

  task automatic b_send(input logic d, input logic sop, input logic eop, input logic md);
    int n;
    n = 0;
    b_in_data = d; b_in_sop = sop; b_in_eop = eop; b_mode = md;
    b_in_valid = 1'b1;
    @(negedge clk);
    while (!b_in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("b_in_ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0; b_in_sop = 1'b0; b_in_eop = 1'b0;
  endtask

  int         base, e0, mism, busy_low, zeros;
  logic [6:0] tx_state;
  logic [7:0] held;
  logic [7:0] ref4[4];
  logic [7:0] ref6[6];
  logic [7:0] pl[64];
  logic [7:0] scr[64];
  logic [7:0] tmp;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_mode = 1'b0; a_seed = 7'h00; a_in_valid = 1'b0; a_in_data = 8'h00;
    a_in_sop = 1'b0; a_in_eop = 1'b0; a_out_ready = 1'b1;
    b_mode = 1'b1; b_seed = 7'h00; b_in_valid = 1'b0; b_in_data = 1'b0;
    b_in_sop = 1'b0; b_in_eop = 1'b0; b_out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_state", 32'(a_state), 32'h5D);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_b_state", 32'(b_state), 32'h5D);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Seed 7F, zero data: 00001110 11110010 -> 0x70, 0x4F, final LFSR 0x72
    base = a_q.size();
    e0 = a_err_cnt;
    a_send(8'h00, 1'b1, 1'b0, 1'b0, 7'h7F);
    a_send(8'h00, 1'b0, 1'b1, 1'b0, 7'h7F);
    idle(3);
    chk("t1_count", 32'(a_q.size() - base), 32'd2);
    chk("t1_beat0", 32'(a_q[base]), 32'h270);
    chk("t1_beat1", 32'(a_q[base+1]), 32'h14F);
    chk("t1_state", 32'(a_state), 32'h72);
    chk("t1_busy", 32'(a_busy), 32'd0);
    chk("t1_err", 32'(a_err_cnt - e0), 32'd0);

    // Zero seed must behave exactly like seed 5D, with one err pulse
    base = a_q.size();
    e0 = a_err_cnt;
    for (int k = 0; k < 4; k++) a_send(8'(k * 37 + 5), k == 0, k == 3, 1'b0, 7'h5D);
    idle(3);
    chk("t2_err_5d", 32'(a_err_cnt - e0), 32'd0);
    for (int k = 0; k < 4; k++) ref4[k] = a_q[base+k][7:0];
    base = a_q.size();
    e0 = a_err_cnt;
    for (int k = 0; k < 4; k++) a_send(8'(k * 37 + 5), k == 0, k == 3, 1'b0, 7'h00);
    idle(3);
    chk("t2_err_zero", 32'(a_err_cnt - e0), 32'd1);
    chk("t2_count", 32'(a_q.size() - base), 32'd4);
    mism = 0;
    for (int k = 0; k < 4; k++) if (a_q[base+k][7:0] !== ref4[k]) mism++;
    chk("t2_stream", 32'(mism), 32'd0);

    // Round trip through the DW=8 instance: TX then RX of the TX output
    for (int k = 0; k < 64; k++) pl[k] = 8'($urandom);
    pl[0] = pl[0] & 8'h80;
    base = a_q.size();
    for (int k = 0; k < 64; k++) a_send(pl[k], k == 0, k == 63, 1'b0, 7'h5D);
    idle(3);
    tx_state = a_state;
    chk("t3_tx_count", 32'(a_q.size() - base), 32'd64);
    for (int k = 0; k < 64; k++) scr[k] = a_q[base+k][7:0];
    base = a_q.size();
    busy_low = 0;
    for (int k = 0; k < 64; k++) begin
      a_send(scr[k], k == 0, k == 63, 1'b1, 7'h11);
      if (k < 63 && !a_busy) busy_low++;
    end
    idle(3);
    chk("t3_rx_count", 32'(a_q.size() - base), 32'd64);
    tmp = a_q[base][7:0];
    chk("t3_rx_bits0_6", 32'(tmp[6:0]), 32'd0);
    mism = 0;
    for (int k = 0; k < 64; k++) if (a_q[base+k][7:0] !== pl[k]) mism++;
    chk("t3_rx_data", 32'(mism), 32'd0);
    chk("t3_busy", 32'(busy_low), 32'd0);
    chk("t3_state", 32'(a_state), 32'(tx_state));

    // DW=1 descrambler on the same scrambled bitstream
    base = b_q.size();
    for (int k = 0; k < 512; k++) begin
      tmp = scr[k/8];
      b_send(tmp[k%8], k == 0, k == 511, 1'b1);
    end
    idle(3);
    chk("t4_count", 32'(b_q.size() - base), 32'd512);
    zeros = 0;
    for (int k = 0; k < 7; k++) if (b_q[base+k][0] === 1'b0) zeros++;
    chk("t4_recover_zero", 32'(zeros), 32'd7);
    mism = 0;
    for (int k = 7; k < 512; k++) begin
      tmp = pl[k/8];
      if (b_q[base+k][0] !== tmp[k%8]) mism++;
    end
    chk("t4_data", 32'(mism), 32'd0);
    chk("t4_sop", 32'(b_q[base][2:1]), 32'd2);
    chk("t4_state", 32'(b_state), 32'(tx_state));
    chk("t4_err", 32'(b_err_cnt), 32'd0);

    // Backpressure: reference run, then the same frame with out_ready low for 3 cycles
    base = a_q.size();
    for (int k = 0; k < 6; k++) a_send(8'(k * 29 + 1), k == 0, k == 5, 1'b0, 7'h7F);
    idle(3);
    for (int k = 0; k < 6; k++) ref6[k] = a_q[base+k][7:0];
    base = a_q.size();
    fork
      begin
        for (int k = 0; k < 6; k++) a_send(8'(k * 29 + 1), k == 0, k == 5, 1'b0, 7'h7F);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        held = a_out_data;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("t5_in_ready", 32'(a_in_ready), 32'd0);
          chk("t5_hold", 32'(a_out_data), 32'(held));
          chk("t5_valid", 32'(a_out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
      end
    join
    idle(3);
    chk("t5_count", 32'(a_q.size() - base), 32'd6);
    mism = 0;
    for (int k = 0; k < 6; k++) if (a_q[base+k][7:0] !== ref6[k]) mism++;
    chk("t5_data", 32'(mism), 32'd0);

    // Reset mid-frame, then a fresh frame
    a_send(8'h00, 1'b1, 1'b0, 1'b0, 7'h7F);
    a_send(8'h05, 1'b0, 1'b0, 1'b0, 7'h7F);
    rst = 1'b1;
    #1;
    chk("t6_out_valid", 32'(a_out_valid), 32'd0);
    chk("t6_state", 32'(a_state), 32'h5D);
    chk("t6_busy", 32'(a_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    base = a_q.size();
    a_send(8'h00, 1'b1, 1'b0, 1'b0, 7'h7F);
    a_send(8'h00, 1'b0, 1'b1, 1'b0, 7'h7F);
    idle(3);
    chk("t6_count", 32'(a_q.size() - base), 32'd2);
    chk("t6_beat0", 32'(a_q[base][7:0]), 32'h70);
    chk("t6_beat1", 32'(a_q[base+1][7:0]), 32'h4F);

    // Non-SOP beat while idle: dropped, err pulse, LFSR untouched
    base = a_q.size();
    e0 = a_err_cnt;
    a_send(8'hAA, 1'b0, 1'b0, 1'b0, 7'h00);
    idle(3);
    chk("t7_err", 32'(a_err_cnt - e0), 32'd1);
    chk("t7_no_output", 32'(a_q.size() - base), 32'd0);
    chk("t7_busy", 32'(a_busy), 32'd0);
    chk("t7_state", 32'(a_state), 32'h72);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
